// File: rtl/sine_nco_pkg.sv
// Shared types and helpers for the quarter-wave LUT sine NCO.
package sine_nco_pkg;
  localparam int LUT_LATENCY  = 1;
  localparam int PIPE_LATENCY = 3;
  localparam int FOLD_W       = 16;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_t;

  // Odd quadrants walk the quarter-wave backwards, so the index is mirrored.
  function automatic logic [FOLD_W-1:0] addr_fold(quadrant_t q, logic [FOLD_W-1:0] k);
    return (q == Q1 || q == Q3) ? ~k : k;
  endfunction
endpackage

// File: rtl/nco_phase_accum.sv
// Phase accumulator: load has priority over advance; exposes quadrant and LUT index.
module nco_phase_accum #(
  parameter int PHASE_BITS = 32,
  parameter int ADDR_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [PHASE_BITS-1:0] phase_inc_i,
  input  logic                  phase_load_i,
  input  logic [PHASE_BITS-1:0] phase_val_i,
  output logic [1:0]            q_o,
  output logic [ADDR_BITS-1:0]  k_o
);
  logic [PHASE_BITS-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (phase_load_i)
      acc_d = phase_val_i;
    else if (en_i)
      acc_d = acc_q + phase_inc_i;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign q_o = acc_q[PHASE_BITS-1 -: 2];
  assign k_o = acc_q[PHASE_BITS-3 -: ADDR_BITS];
endmodule

// File: rtl/sine_nco.sv
// Full-wave sine NCO: folds phase into a quarter-wave LUT address and
// rebuilds the signed sample from the external LUT's registered data.
module sine_nco
  import sine_nco_pkg::*;
#(
  parameter int PHASE_BITS = 32,
  parameter int ADDR_BITS  = 8,
  parameter int DW         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [PHASE_BITS-1:0] phase_inc_i,
  input  logic                  phase_load_i,
  input  logic [PHASE_BITS-1:0] phase_val_i,
  output logic [ADDR_BITS-1:0]  lut_addr_o,
  input  logic [DW-1:0]         lut_sample_i,
  output logic [DW-1:0]         sample_o,
  output logic                  valid_o
);
  logic [1:0]           q;
  logic [ADDR_BITS-1:0] k;

  nco_phase_accum #(.PHASE_BITS(PHASE_BITS), .ADDR_BITS(ADDR_BITS)) u_accum (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .phase_inc_i  (phase_inc_i),
    .phase_load_i (phase_load_i),
    .phase_val_i  (phase_val_i),
    .q_o          (q),
    .k_o          (k)
  );

  logic [ADDR_BITS-1:0] lut_addr_q, lut_addr_d;
  logic                 neg1_q, neg1_d, neg2_q, neg2_d;
  logic                 v1_q, v1_d, v2_q, v2_d;
  logic [DW-1:0]        sample_q, sample_d;
  logic                 valid_q, valid_d;
  logic [DW-1:0]        mag;

  always_comb begin
    // Stage 1 sees the accumulator before this edge's update.
    lut_addr_d = ADDR_BITS'(addr_fold(quadrant_t'(q), FOLD_W'(k)));
    neg1_d     = q[1];
    v1_d       = en_i;
    neg2_d     = neg1_q;
    v2_d       = v1_q;
    // Magnitude is capped below full scale so negation can never reach the most negative code.
    mag        = lut_sample_i[DW-1] ? {1'b0, {(DW-1){1'b1}}} : lut_sample_i;
    sample_d   = sample_q;
    if (v2_q)
      sample_d = neg2_q ? -mag : mag;
    valid_d    = v2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lut_addr_q <= '0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      lut_addr_q <= lut_addr_d;
      neg1_q     <= neg1_d;
      neg2_q     <= neg2_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
    end
  end

  assign lut_addr_o = lut_addr_q;
  assign sample_o   = sample_q;
  assign valid_o    = valid_q;
endmodule
